beam_delay_scheduler: RTL

BEAM_DELAY_SCHEDULER -- requirements
Module: beam_delay_scheduler

---
 rtl/beam_pkg.sv | 20 ++
 rtl/delay_table_ram.sv | 33 +++
 rtl/beam_delay_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared sizing constants and FSM state type for the beam delay scheduler
// Contents:
//   NUM_CH, NUM_ZONES, DELAY_W, CNT_W  default geometry
//   MIN_ZONE_LEN                       shortest zone that still lets a prefetch finish
//   state_t                            scheduler state encoding
package beam_pkg;

  localparam int NUM_CH       = 8;
  localparam int NUM_ZONES    = 4;
  localparam int DELAY_W      = 8;
  localparam int CNT_W        = 16;
  localparam int MIN_ZONE_LEN = NUM_CH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_table_ram.sv
// rtl/delay_table_ram.sv - simple dual-port delay table, one write port, registered read port
// Ports:
//   clk                      clock
//   i_wr_en/addr/data        write port
//   i_rd_addr                read address, data appears on o_rd_data one cycle later
//   o_rd_data                registered read data
module delay_table_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  // Contents are deliberately not reset: the table is reloaded by software.
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/beam_delay_scheduler.sv
// rtl/beam_delay_scheduler.sv - per-zone receive delay scheduler for one scan line
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_we/addr/data    delay-table write (addr = zone*NUM_CH + ch), accepted in IDLE only
//   len_we/zone/data    zone-length write, accepted in IDLE only, clamped up to NUM_CH+2
//   start, abort        begin / cancel a scan line (abort wins)
//   sample_valid        one ADC sample accepted this cycle
//   delay_vec           active delays, channel c at [c*DELAY_W +: DELAY_W]
//   delay_commit        one-cycle pulse when delay_vec is loaded
//   zone_idx, busy      active zone; high outside IDLE
//   line_done, cfg_err  one-cycle pulses: end of line / rejected write
module beam_delay_scheduler #(
  parameter int NUM_CH    = beam_pkg::NUM_CH,
  parameter int NUM_ZONES = beam_pkg::NUM_ZONES,
  parameter int DELAY_W   = beam_pkg::DELAY_W,
  parameter int CNT_W     = beam_pkg::CNT_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_we,
  input  logic [$clog2(NUM_CH*NUM_ZONES)-1:0]   cfg_addr,
  input  logic [DELAY_W-1:0]                    cfg_data,
  input  logic                                  len_we,
  input  logic [$clog2(NUM_ZONES)-1:0]          len_zone,
  input  logic [CNT_W-1:0]                      len_data,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  sample_valid,
  output logic [NUM_CH*DELAY_W-1:0]             delay_vec,
  output logic                                  delay_commit,
  output logic [$clog2(NUM_ZONES)-1:0]          zone_idx,
  output logic                                  busy,
  output logic                                  line_done,
  output logic                                  cfg_err
);
  import beam_pkg::*;

  localparam int AW  = $clog2(NUM_CH*NUM_ZONES);
  localparam int ZW  = $clog2(NUM_ZONES);
  localparam int PCW = $clog2(NUM_CH+1);
  localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(NUM_CH + 2);
  localparam logic [ZW-1:0]    LAST_ZONE = ZW'(NUM_ZONES - 1);
  localparam logic [PCW-1:0]   PF_LAST   = PCW'(NUM_CH);

  state_t                    r_state;
  logic [ZW-1:0]             r_zone_idx;
  logic [CNT_W-1:0]          r_sample_cnt;
  logic [CNT_W-1:0]          r_zone_len [NUM_ZONES];
  logic [NUM_CH*DELAY_W-1:0] r_shadow;
  logic [NUM_CH*DELAY_W-1:0] r_delay_vec;
  logic                      r_commit;
  logic                      r_line_done;
  logic                      r_cfg_err;
  // Prefetch engine: walks r_pf_cnt 0..NUM_CH, issuing reads for 0..NUM_CH-1 and
  // capturing the previous read into the shadow, so it spans NUM_CH+1 cycles.
  logic                      r_pf_active;
  logic [PCW-1:0]            r_pf_cnt;
  logic [ZW-1:0]             r_pf_zone;

  logic                      w_idle;
  logic                      w_addr_ok;
  logic                      w_tbl_we;
  logic                      w_len_we;
  logic [CNT_W-1:0]          w_len_clamped;
  logic [CNT_W-1:0]          w_last_cnt;
  logic [AW-1:0]             w_rd_addr;
  logic [DELAY_W-1:0]        w_rd_data;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_addr_ok     = int'(cfg_addr) < NUM_CH*NUM_ZONES;
  assign w_tbl_we      = w_idle & cfg_we & w_addr_ok;
  assign w_len_we      = w_idle & len_we & (int'(len_zone) < NUM_ZONES);
  assign w_len_clamped = (len_data < MIN_LEN) ? MIN_LEN : len_data;
  assign w_last_cnt    = r_zone_len[r_zone_idx] - CNT_W'(1);
  assign w_rd_addr     = AW'(r_pf_zone) * AW'(NUM_CH) + AW'(r_pf_cnt);

  delay_table_ram #(
    .DEPTH (NUM_CH*NUM_ZONES),
    .AW    (AW),
    .DW    (DELAY_W)
  ) u_table (
    .clk       (clk),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_zone_idx   <= '0;
      r_sample_cnt <= '0;
      r_shadow     <= '0;
      r_delay_vec  <= '0;
      r_commit     <= 1'b0;
      r_line_done  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_pf_active  <= 1'b0;
      r_pf_cnt     <= '0;
      r_pf_zone    <= '0;
      for (int z = 0; z < NUM_ZONES; z++) begin
        r_zone_len[z] <= MIN_LEN;
      end
    end else begin
      r_commit    <= 1'b0;
      r_line_done <= 1'b0;
      r_cfg_err   <= ((cfg_we | len_we) & ~w_idle) | (cfg_we & w_idle & ~w_addr_ok);

      if (w_len_we) begin
        r_zone_len[len_zone] <= w_len_clamped;
      end

      if (r_pf_active) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_pf_cnt == PCW'(c + 1)) begin
            r_shadow[c*DELAY_W +: DELAY_W] <= w_rd_data;
          end
        end
        if (r_pf_cnt == PF_LAST) begin
          r_pf_active <= 1'b0;
        end
        r_pf_cnt <= r_pf_cnt + PCW'(1);
      end

      if (abort) begin
        r_state     <= ST_IDLE;
        r_pf_active <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_FILL;
              r_zone_idx  <= '0;
              r_pf_active <= 1'b1;
              r_pf_cnt    <= '0;
              r_pf_zone   <= '0;
            end
          end
          ST_FILL: begin
            if (!r_pf_active) begin
              r_delay_vec  <= r_shadow;
              r_commit     <= 1'b1;
              r_sample_cnt <= '0;
              r_state      <= ST_RUN;
              if (LAST_ZONE != '0) begin
                r_pf_active <= 1'b1;
                r_pf_cnt    <= '0;
                r_pf_zone   <= ZW'(1);
              end
            end
          end
          ST_RUN: begin
            if (sample_valid) begin
              if (r_sample_cnt == w_last_cnt) begin
                if (r_zone_idx == LAST_ZONE) begin
                  r_line_done <= 1'b1;
                  r_state     <= ST_IDLE;
                end else begin
                  r_delay_vec  <= r_shadow;
                  r_commit     <= 1'b1;
                  r_zone_idx   <= r_zone_idx + ZW'(1);
                  r_sample_cnt <= '0;
                  // No prefetch once the newly entered zone is the last one.
                  if (r_zone_idx + ZW'(1) != LAST_ZONE) begin
                    r_pf_active <= 1'b1;
                    r_pf_cnt    <= '0;
                    r_pf_zone   <= r_zone_idx + ZW'(2);
                  end
                end
              end else begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign delay_vec    = r_delay_vec;
  assign delay_commit = r_commit;
  assign zone_idx     = r_zone_idx;
  assign busy         = ~w_idle;
  assign line_done    = r_line_done;
  assign cfg_err      = r_cfg_err;

endmodule
